// File: rtl/bus_requester.sv
// Byte-serial to Wishbone bridge: decodes {we,adr} command frames from the rx stream,
// runs one Wishbone cycle with a timeout, and returns a status byte plus read data on tx.
module bus_requester #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        wb_we_o,
    output logic [6:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [2:0] {CMD, DATA, BUS, STATUS, RDATA} state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t      state, next_state;
    logic [1:0]  cnt;
    logic [7:0]  tcnt;
    logic [7:0]  status;
    logic [31:0] rdata;
    logic        rx_fire, tx_fire, ack_ok, expire;

    assign rx_fire = rx_valid && rx_ready;
    assign tx_fire = tx_valid && tx_ready;
    // Ack is only meaningful while the strobe is out; ack wins over a same-cycle expiry.
    assign ack_ok  = wb_stb_o && wb_ack_i;
    assign expire  = wb_stb_o && !wb_ack_i && (tcnt == TLAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= CMD;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
        next_state = state;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        case (state)
            CMD: begin
                rx_ready = 1'b1;
                if (rx_fire) next_state = rx_data[7] ? DATA : BUS;
            end
            DATA: begin
                rx_ready = 1'b1;
                if (rx_fire && cnt == 2'd3) next_state = BUS;
            end
            BUS: begin
                if (ack_ok || expire) next_state = STATUS;
            end
            STATUS: begin
                tx_valid = 1'b1;
                if (tx_fire) next_state = (!wb_we_o && status == 8'h00) ? RDATA : CMD;
            end
            RDATA: begin
                tx_valid = 1'b1;
                if (tx_fire && cnt == 2'd3) next_state = CMD;
            end
            default: next_state = CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: every register here is a plain flop (no memory array), so all of them are reset.
        if (rst) begin
            cnt      <= '0;
            tcnt     <= '0;
            status   <= '0;
            rdata    <= '0;
            tx_data  <= '0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
        end else begin
            // Strobe and cycle are registered copies of "in BUS next cycle".
            wb_stb_o <= (next_state == BUS);
            wb_cyc_o <= (next_state == BUS);
            if (state != BUS) tcnt <= '0;
            case (state)
                CMD: begin
                    if (rx_fire) begin
                        wb_we_o  <= rx_data[7];
                        wb_adr_o <= rx_data[6:0];
                        wb_dat_o <= '0;
                        cnt      <= '0;
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        cnt      <= cnt + 2'd1;
                    end
                end
                BUS: begin
                    if (ack_ok) begin
                        rdata   <= wb_we_o ? 32'h0 : wb_dat_i;
                        status  <= 8'h00;
                        tx_data <= 8'h00;
                    end else if (expire) begin
                        rdata   <= '0;
                        status  <= 8'hFF;
                        tx_data <= 8'hFF;
                    end else if (wb_stb_o) begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                STATUS, RDATA: begin
                    // Read data drains MSB first through a shift register into tx_data.
                    if (tx_fire) begin
                        tx_data <= rdata[31:24];
                        rdata   <= {rdata[23:0], 8'h00};
                        cnt     <= (state == STATUS) ? 2'd0 : cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester: tx bytes are predicted into a scoreboard queue as
// stimulus is driven and compared as the DUT emits them; Wishbone outputs checked inline.
module tb_bus_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wb_stb_o, wb_cyc_o, wb_we_o;
    logic [6:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    bus_requester #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", rx_ready, 1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h5A;
    endtask

    // Called at the negedge of the first strobe cycle; acks in strobe cycle d.
    task automatic do_bus(input string tag, input int d, input logic [31:0] rd,
                          input logic exp_we, input logic [6:0] exp_adr, input logic [31:0] exp_dat);
        for (int i = 1; i <= d; i++) begin
            check({tag, " stb"}, wb_stb_o, 1);
            check({tag, " cyc"}, wb_cyc_o, 1);
            check({tag, " we"},  wb_we_o, exp_we);
            check({tag, " adr"}, wb_adr_o, exp_adr);
            if (exp_we) check({tag, " dat"}, wb_dat_o, exp_dat);
            if (i == d) begin
                wb_ack_i = 1'b1;
                wb_dat_i = rd;
            end
            @(negedge clk);
        end
        wb_ack_i = 1'b0;
        wb_dat_i = 32'hA5A5_5A5A;
        check({tag, " stb_drop"}, wb_stb_o, 0);
        check({tag, " cyc_drop"}, wb_cyc_o, 0);
        sb.push_back(8'h00);
        if (!exp_we) begin
            sb.push_back(rd[31:24]);
            sb.push_back(rd[23:16]);
            sb.push_back(rd[15:8]);
            sb.push_back(rd[7:0]);
        end
    endtask

    // Consumes n tx bytes against the scoreboard, optionally toggling tx_ready each cycle.
    task automatic collect_tx(input string tag, input int n, input bit toggle);
        int         got = 0;
        int         guard = 0;
        logic [7:0] held = '0;
        logic [7:0] exp;
        bit         holding = 1'b0;
        bit         rdy = 1'b1;
        while (got < n && guard < 200) begin
            tx_ready = rdy;
            if (holding) begin
                check({tag, " hold_valid"}, tx_valid, 1);
                check({tag, " hold_data"}, tx_data, held);
                holding = 1'b0;
            end
            if (tx_valid === 1'b1) begin
                if (rdy) begin
                    if (sb.size() == 0) begin
                        check({tag, " unexpected_tx"}, tx_data, 32'hFFFF_FFFF);
                    end else begin
                        exp = sb.pop_front();
                        check({tag, " tx_byte"}, tx_data, exp);
                    end
                    got++;
                end else begin
                    holding = 1'b1;
                    held    = tx_data;
                end
            end
            @(negedge clk);
            guard++;
            if (toggle) rdy = !rdy;
        end
        tx_ready = 1'b0;
        check({tag, " tx_count"}, got, n);
        check({tag, " sb_empty"}, sb.size(), 0);
        check({tag, " tx_idle"}, tx_valid, 0);
        check({tag, " rx_back"}, rx_ready, 1);
    endtask

    initial begin
        int cyc_count;
        rst      = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        wb_dat_i = '0;
        wb_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst rx_ready", rx_ready, 1);
        check("rst tx_valid", tx_valid, 0);
        check("rst stb", wb_stb_o, 0);
        check("rst cyc", wb_cyc_o, 0);
        check("rst we", wb_we_o, 0);
        check("rst adr", wb_adr_o, 0);
        check("rst dat", wb_dat_o, 0);
        check("rst tx_data", tx_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Stray ack while idle must do nothing.
        wb_ack_i = 1'b1;
        repeat (3) @(negedge clk);
        wb_ack_i = 1'b0;
        check("idle_ack stb", wb_stb_o, 0);
        check("idle_ack tx_valid", tx_valid, 0);
        check("idle_ack rx_ready", rx_ready, 1);

        // Write with ack two cycles after the strobe rises.
        send_byte(8'h92); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        do_bus("write", 3, 32'h1111_2222, 1'b1, 7'h12, 32'hDEAD_BEEF);
        collect_tx("write", 1, 1'b0);

        // Minimum-latency write: ack in first strobe cycle, status valid the next cycle.
        send_byte(8'hC5); send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
        do_bus("write_fast", 1, 32'h0, 1'b1, 7'h45, 32'h0123_4567);
        check("write_fast tx_valid", tx_valid, 1);
        collect_tx("write_fast", 1, 1'b0);

        // Read.
        send_byte(8'h70);
        do_bus("read", 2, 32'h0102_0304, 1'b0, 7'h70, 32'h0);
        collect_tx("read", 5, 1'b0);

        // Timeout: strobe must stay up exactly TIMEOUT cycles.
        send_byte(8'h15);
        sb.push_back(8'hFF);
        cyc_count = 0;
        while (wb_stb_o === 1'b1 && cyc_count < 300) begin
            cyc_count++;
            @(negedge clk);
        end
        check("timeout stb_cycles", cyc_count, 8);
        check("timeout cyc", wb_cyc_o, 0);
        collect_tx("timeout", 1, 1'b0);

        // Ack on the expiry cycle counts as success.
        send_byte(8'h15);
        do_bus("ack_expiry", 8, 32'hCAFE_F00D, 1'b0, 7'h15, 32'h0);
        collect_tx("ack_expiry", 5, 1'b0);

        // Backpressure on the read response.
        send_byte(8'h33);
        do_bus("backpressure", 2, 32'hB3B2_B1B0, 1'b0, 7'h33, 32'h0);
        collect_tx("backpressure", 5, 1'b1);

        // Reset during the bus cycle aborts without a response.
        send_byte(8'h15);
        check("rst_bus stb_up", wb_stb_o, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_bus stb", wb_stb_o, 0);
        check("rst_bus cyc", wb_cyc_o, 0);
        check("rst_bus tx_valid", tx_valid, 0);
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bus no_resp", tx_valid, 0);
        tx_ready = 1'b0;
        send_byte(8'h70);
        do_bus("after_rst", 2, 32'h1122_3344, 1'b0, 7'h70, 32'h0);
        collect_tx("after_rst", 5, 1'b0);

        // Reset mid-frame discards the partial write.
        send_byte(8'h92); send_byte(8'hDE);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_frame rx_ready", rx_ready, 1);
        send_byte(8'h70);
        do_bus("after_frame_rst", 1, 32'h5566_7788, 1'b0, 7'h70, 32'h0);
        collect_tx("after_frame_rst", 5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_requester.md
BUS_REQUESTER -- requirements
Module: bus_requester

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles wb_stb_o stays high awaiting wb_ack_i (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rx_data  input  8  command byte from serial front end.
REQ-005 rx_valid  input  1  rx_data valid.
REQ-006 rx_ready  output  1  block accepts rx_data this cycle.
REQ-007 tx_data  output  8  response byte to serial front end.
REQ-008 tx_valid  output  1  tx_data valid.
REQ-009 tx_ready  input  1  front end accepts tx_data this cycle.
REQ-010 wb_stb_o, wb_cyc_o, wb_we_o  output  1 each  wishbone initiator strobe, cycle, write-enable.
REQ-011 wb_adr_o  output  7  wishbone address (bits [6:4] select module, [3:0] register).
REQ-012 wb_dat_o  output  32  write data; wb_dat_i  input  32  read data; wb_ack_i  input  1  responder acknowledge.

Function
REQ-013 Byte transfer SHALL occur only on a clock edge with valid and ready both high (rx and tx alike).
REQ-014 Command frame SHALL be: header byte {we, adr[6:0]}; if we=1, 4 data bytes MSB first; if we=0, header only.
REQ-015 FSM states SHALL be CMD, DATA, BUS, STATUS, RDATA.
REQ-016 CMD: rx_ready=1; header accepted -> latch we/adr; we=1 -> DATA with byte count 0, we=0 -> BUS.
REQ-017 DATA: rx_ready=1; each accepted byte shifts into 32-bit write register; 4th byte -> BUS.
REQ-018 rx_ready SHALL be 0 in BUS, STATUS, RDATA; no rx byte is consumed there.
REQ-019 BUS: wb_stb_o=wb_cyc_o=1 from the first cycle after the final command byte is accepted; wb_we_o, wb_adr_o, wb_dat_o held stable throughout.
REQ-020 BUS: timeout counter SHALL clear on BUS entry and increment each cycle stb is high without ack.
REQ-021 ack sampled high -> latch wb_dat_i (reads only, else 0), status=0x00, deassert stb/cyc next cycle, -> STATUS.
REQ-022 Counter reaching TIMEOUT without ack -> status=0xFF, read data=0, deassert stb/cyc next cycle, -> STATUS.
REQ-023 ack in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-024 ack while stb=0 SHALL be ignored.
REQ-025 STATUS: tx_valid=1, tx_data=status; on transfer -> RDATA if we=0 and status=0x00, else CMD.
REQ-026 RDATA: 4 bytes of latched read data, MSB first; after 4th transfer -> CMD.
REQ-027 tx_data SHALL remain stable while tx_valid=1 and tx_ready=0; tx_valid SHALL not drop until transfer.
REQ-028 Minimum write latency: 5th rx transfer at edge N -> stb high cycle N+1; ack at edge N+1 -> status byte valid cycle N+2.
REQ-029 Wishbone outputs and tx_data SHALL be registered (no combinational path from rx/ack inputs to them).

Reset
REQ-030 rst=1 at an edge SHALL set state CMD, byte count 0, timeout counter 0, status 0, data registers 0.
REQ-031 After reset: rx_ready=1, tx_valid=0, wb_stb_o=wb_cyc_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, tx_data=0.
REQ-032 Reset mid-frame or mid-bus-cycle SHALL abort: partial frame discarded, stb/cyc low the cycle after reset edge, no response byte emitted.

Verification
REQ-033 Write: rx 0x92,DE,AD,BE,EF; ack 2 cycles later -> wb_we_o=1, adr=0x12, dat=0xDEADBEEF, tx 0x00 only.
REQ-034 Read: rx 0x70; ack with wb_dat_i=0x01020304 -> we=0, adr=0x70, tx 00,01,02,03,04.
REQ-035 Timeout: TIMEOUT=8, rx 0x15, no ack -> stb high exactly 8 cycles, tx 0xFF only, then rx_ready=1.
REQ-036 Ack on expiry cycle: TIMEOUT=8, ack on 8th stb cycle, read -> tx 0x00 then 4 data bytes.
REQ-037 Backpressure: read response with tx_ready toggling 1/0 each cycle -> each byte held stable, order 00,B3,B2,B1,B0.
REQ-038 Reset mid-cycle: rst during BUS -> stb/cyc 0 next cycle, tx_valid 0, next frame 0x70 processed normally.
